adder_tree: RTL and testbench

//  - Pipelined unsigned binary adder tree that sums KERNEL_SIZE packed products into one word.
//  - Sits after the multiplier array of the convolution datapath.
//  - Produces one dot-product partial sum per enabled cycle, fully pipelined (1 result/clk).

---
 rtl/adder_tree.sv | 110 +++++++++++
 tb/tb_adder_tree.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/adder_tree.sv
// adder_tree: pipelined unsigned adder tree for the convolution datapath.
// It sums KERNEL_SIZE packed products into one word and produces one result per enabled clock.
// Latency is $clog2(KERNEL_SIZE)+1 enabled edges from input sample to output update.
// When adder_en is low, the whole pipeline stalls and holds its contents.
// Optional build macro ADDER_TREE_VALID_EN adds the adder_valid output. This output marks
// adder_dataOut as holding a real result rather than reset or fill data.
module adder_tree #(
    parameter int KERNEL_SIZE  = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8
) (
    input  logic                                                   clk,
    input  logic                                                   rstn,
    input  logic                                                   adder_en,
    input  logic [(DATA_WIDTH+WEIGHT_WIDTH)*KERNEL_SIZE-1:0]       adder_dataIn,
    output logic [DATA_WIDTH+WEIGHT_WIDTH+KERNEL_SIZE-1:0]         adder_dataOut
`ifdef ADDER_TREE_VALID_EN
    ,
    output logic                                                   adder_valid
`endif
);

    localparam int PRODUCT_WIDTH   = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int FINAL_OUT_WIDTH = DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE;
    localparam int LEVELS          = $clog2(KERNEL_SIZE);

    // Number of operands alive at a given tree level: each level halves the count, rounding up.
    function automatic int nodes_at(input int lvl);
        int n;
        n = KERNEL_SIZE;
        for (int i = 0; i < lvl; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    // Level 0 holds the unpacked operands. Level l holds ceil(K/2^l) partial sums that are
    // PRODUCT_WIDTH+l bits wide. This width is exactly enough to hold a sum of 2^l operands.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int N  = nodes_at(l);
        localparam int NP = nodes_at(l - 1);
        localparam int W  = PRODUCT_WIDTH + l;

        for (genvar k = 0; k < N; k++) begin : g_node
            logic [W-1:0] sum_r;

            if (l == 0) begin : g_load
                // Capture operand k from the packed input bus
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        sum_r <= '0;
                    end else if (adder_en) begin
                        sum_r <= adder_dataIn[(k+1)*PRODUCT_WIDTH-1 -: PRODUCT_WIDTH];
                    end
                end
            end else if ((2 * k + 1) < NP) begin : g_pair
                // Add an adjacent pair from the previous level into a register that is one bit wider
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        sum_r <= '0;
                    end else if (adder_en) begin
                        sum_r <= {1'b0, g_lvl[l-1].g_node[2*k].sum_r}
                               + {1'b0, g_lvl[l-1].g_node[2*k+1].sum_r};
                    end
                end
            end else begin : g_odd
                // Odd leftover operand: zero-extend it by one bit and register it unchanged
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        sum_r <= '0;
                    end else if (adder_en) begin
                        sum_r <= {1'b0, g_lvl[l-1].g_node[2*k].sum_r};
                    end
                end
            end
        end
    end

    // The last-level register is the output. No logic sits between it and the port,
    // apart from the constant zero-extension.
    assign adder_dataOut = {{(FINAL_OUT_WIDTH - PRODUCT_WIDTH - LEVELS){1'b0}},
                            g_lvl[LEVELS].g_node[0].sum_r};

`ifdef ADDER_TREE_VALID_EN
    logic [LEVELS:0] valid_sr_r;

    if (LEVELS == 0) begin : g_valid_one
        // Single-stage pipe: the flag sets on the first enabled edge after reset
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                valid_sr_r <= 1'b0;
            end else if (adder_en) begin
                valid_sr_r <= 1'b1;
            end
        end
    end else begin : g_valid_multi
        // Shift a one through a register whose depth matches the data pipeline
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                valid_sr_r <= '0;
            end else if (adder_en) begin
                valid_sr_r <= {valid_sr_r[LEVELS-1:0], 1'b1};
            end
        end
    end

    assign adder_valid = valid_sr_r[LEVELS];
`endif

endmodule

// File: tb/tb_adder_tree.sv
// Self-checking bench for adder_tree. The bench uses a scoreboard: the driver pushes the
// expected sum for every enabled sample, and an independent monitor pops and compares after
// every clock edge. The monitor also checks that the output holds during stalls.
module tb_adder_tree;

    localparam int K   = 3;
    localparam int DW  = 8;
    localparam int WW  = 8;
    localparam int PW  = DW + WW;
    localparam int IW  = PW * K;
    localparam int OW  = DW + WW + K;
    localparam int LAT = $clog2(K) + 1;

    logic          clk;
    logic          rstn;
    logic          adder_en;
    logic [IW-1:0] adder_dataIn;
    logic [OW-1:0] adder_dataOut;
`ifdef ADDER_TREE_VALID_EN
    logic          adder_valid;
`endif

    int checks;
    int failures;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] last_exp;
    int            en_edges;
    string         phase;

    adder_tree #(.KERNEL_SIZE(K), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .adder_en     (adder_en),
        .adder_dataIn (adder_dataIn),
        .adder_dataOut(adder_dataOut)
`ifdef ADDER_TREE_VALID_EN
        ,
        .adder_valid  (adder_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arithmetic sum of the K unsigned operands
    function automatic logic [OW-1:0] ref_sum(input logic [IW-1:0] v);
        longint unsigned s;
        s = 0;
        for (int k = 0; k < K; k++) s += longint'(v[k*PW +: PW]);
        return OW'(s);
    endfunction

    task automatic check_out(input string name, input logic [OW-1:0] got, input logic [OW-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0d want=%0d t=%0t", name, got, want, $time);
        end
    endtask

    // Pipeline contents after reset are zero; LAT-1 fill values come out before the first real result
    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back('0);
        last_exp = '0;
        en_edges = 0;
    endtask

    // One stimulus cycle: drive on the falling edge and record the expected result if it will be sampled
    task automatic drive(input logic [IW-1:0] d, input logic en, input logic [OW-1:0] want);
        @(negedge clk);
        adder_dataIn = d;
        adder_en     = en;
        if (en) exp_q.push_back(want);
    endtask

    // Monitor: after each edge, compare against the next queued result, or check the hold during a stall
    initial begin : monitor
        logic en_s;
        logic rst_s;
        forever begin
            @(posedge clk);
            en_s  = adder_en;
            rst_s = !rstn;
            #1;
            if (!rst_s) begin
                if (en_s) begin
                    en_edges++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL %s: scoreboard empty got=%0d want=queued value", phase, adder_dataOut);
                    end else begin
                        last_exp = exp_q.pop_front();
                        check_out(phase, adder_dataOut, last_exp);
                    end
                end else begin
                    check_out({phase, "_hold"}, adder_dataOut, last_exp);
                end
`ifdef ADDER_TREE_VALID_EN
                checks++;
                if (adder_valid !== (en_edges >= LAT)) begin
                    failures++;
                    $display("FAIL valid_%s: got=%0b want=%0b", phase, adder_valid, (en_edges >= LAT));
                end
`endif
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [IW-1:0] d;
        logic [IW-1:0] ones;
        checks   = 0;
        failures = 0;
        phase    = "reset";
        rstn         = 1'b0;
        adder_en     = 1'b0;
        adder_dataIn = '0;
        clear_model();
        #12;
        check_out("reset_state", adder_dataOut, '0);
        @(negedge clk);
        #2 rstn = 1'b1;

        // Basic: 1+2+3
        phase = "basic";
        drive({16'd3, 16'd2, 16'd1}, 1'b1, 19'd6);

        // Max: every operand all ones, no wrap
        phase = "max";
        ones = '1;
        drive(ones, 1'b1, 19'd196605);

        // Stream 1..8 back-to-back, with a 4-cycle stall in the middle
        phase = "stream";
        for (int n = 1; n <= 8; n++) begin
            d = '0;
            d[PW-1:0] = PW'(n);
            drive(d, 1'b1, OW'(n));
            if (n == 4) begin
                for (int s = 0; s < 4; s++) drive(d, 1'b0, '0);
            end
        end

        // Asynchronous reset mid-cycle while the pipeline holds nonzero data
        phase = "midreset";
        @(negedge clk);
        adder_en = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check_out("async_reset", adder_dataOut, '0);
        clear_model();
        @(negedge clk);
        check_out("reset_hold", adder_dataOut, '0);
        #2 rstn = 1'b1;

        // After reset release, fill zeros come out first, then the new data
        phase = "post_reset";
        drive({16'd10, 16'd20, 16'd30}, 1'b1, 19'd60);
        drive({16'd100, 16'd200, 16'd300}, 1'b1, 19'd600);

        // Random sweep: each vector is held 10 cycles, with occasional stall cycles
        phase = "sweep";
        for (int v = 0; v < 1500; v++) begin
            for (int k = 0; k < K; k++) begin
                if ($urandom_range(0, 7) == 0) d[k*PW +: PW] = '1;
                else                           d[k*PW +: PW] = PW'($urandom);
            end
            for (int h = 0; h < 10; h++) begin
                logic en;
                en = ($urandom_range(0, 9) != 0);
                drive(d, en, ref_sum(d));
            end
        end

        // Drain so every queued result is compared
        phase = "drain";
        for (int i = 0; i < LAT; i++) drive('0, 1'b1, '0);
        @(negedge clk);
        checks++;
        if (exp_q.size() != LAT - 1) begin
            failures++;
            $display("FAIL drain_depth: got=%0d want=%0d", exp_q.size(), LAT - 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
